neuron_stream_loader: RTL

Upstream feeder for the sequential neuron (start/done handshake, packed N×WIDTH x vector, 2*WIDTH+2-bit signed y).
- Input side: collects a serial valid/ready stream of signed samples into the packed x vector.
- Neuron side: fires a one-cycle start, waits for done, captures y.
- Output side: requantizes y to WIDTH bits and presents it on a valid/ready output stream.
- Weights and bias are not handled here; they go to the neuron directly.

---
 rtl/neuron_stream_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/neuron_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_stream_loader
//  Description : Collects a serial stream of signed samples into a packed
//                vector, starts the sequential neuron, captures its result,
//                requantizes it and presents it on an output stream.
//                Optional macro LOADER_SAT_EN: saturate instead of wrap when
//                narrowing the shifted result.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_stream_loader #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   nrn_start,
    output logic [N*WIDTH-1:0]     nrn_x,
    input  logic                   nrn_done,
    input  logic [2*WIDTH+1:0]     nrn_y,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int YW = 2*WIDTH + 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [N*WIDTH-1:0]    x_q, x_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [WIDTH-1:0]      y_req;

`ifdef LOADER_SAT_EN
    localparam logic signed [YW-1:0] c_max = {{(YW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [YW-1:0] c_min = {{(YW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic signed [YW-1:0] y_shift;
    assign y_shift = $signed(nrn_y) >>> SHIFT;

    // Clamp the shifted result into the signed output range.
    always_comb begin
        if (y_shift > c_max)
            y_req = c_max[WIDTH-1:0];
        else if (y_shift < c_min)
            y_req = c_min[WIDTH-1:0];
        else
            y_req = y_shift[WIDTH-1:0];
    end
`else
    // Plain wrap-around narrowing of the shifted result.
    assign y_req = WIDTH'($signed(nrn_y) >>> SHIFT);
`endif

    // Next-state and datapath updates for the fill / fire / wait / output sequence.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        x_d         = x_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_FILL: begin
                if (clear) begin
                    count_d = '0;
                end else if (in_valid) begin
                    x_d[count_q*WIDTH +: WIDTH] = in_data;
                    if (count_q == c_last) begin
                        count_d = '0;
                        state_d = S_FIRE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // clear is deliberately ignored so a neuron run is never abandoned
                if (nrn_done) begin
                    out_data_d  = y_req;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (clear || out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            count_q     <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == S_FILL) && !rst;
    assign nrn_start = (state_q == S_FIRE);
    assign nrn_x     = x_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_FILL);

endmodule
`default_nettype wire
